carry_chain_seq: RTL and testbench

- Multi-cycle sequencer that runs one wide ALU operation (N words of W bits) through a single W-bit slice, one word per cycle, least-significant word first.
- Latches each slice's carry-out and feeds it back as the next word's carry-in. It is the consumer end of the slice carry-out interface.
- Sits between the operand/opcode source and the result/flags consumer. Valid/ready handshake on both sides.

---
 rtl/alu_pkg.sv | 18 +
 rtl/carry_chain_seq_if.sv | 20 ++
 rtl/alu_word_slice.sv | 35 +++
 rtl/carry_chain_seq.sv | 108 ++++++++++
 tb/tb_carry_chain_seq.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode and sequencer state types shared by the word slice and the carry-chain sequencer.
package alu_pkg;
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_NOT = 3'b011,
        OP_ADD = 3'b100,
        OP_SHL = 3'b101,
        OP_SUB = 3'b110,
        OP_RSV = 3'b111
    } opsel_e;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;

    localparam logic [2:0] OP_RESERVED    = 3'b111;
    localparam logic       SUB_INIT_CARRY = 1'b1;
endpackage

// File: rtl/carry_chain_seq_if.sv
// carry_chain_seq_if: request/response bundle between the operand source, the sequencer and the result consumer.
interface carry_chain_seq_if #(parameter int W = 8, parameter int N = 4);
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     opsel;
    logic [W*N-1:0] op_a;
    logic [W*N-1:0] op_b;
    logic           cin;
    logic           out_valid;
    logic           out_ready;
    logic [W*N-1:0] result;
    logic           cout;
    logic           zero;
    logic           err;

    modport master (output in_valid, opsel, op_a, op_b, cin, out_ready,
                    input  in_ready, out_valid, result, cout, zero, err);
    modport slave  (input  in_valid, opsel, op_a, op_b, cin, out_ready,
                    output in_ready, out_valid, result, cout, zero, err);
endinterface

// File: rtl/alu_word_slice.sv
// alu_word_slice: combinational W-bit ALU slice producing one result word and its carry-out.
module alu_word_slice
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  opsel_e         i_opsel,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic           i_ci,
    output logic [W-1:0]   o_s,
    output logic           o_co
);
    logic [W:0] w_add;
    logic [W:0] w_sub;

    assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_ci};
    // Subtract as a + ~b + ci; carry-out high means no borrow.
    assign w_sub = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, i_ci};

    always_comb begin
        o_s  = '0;
        o_co = 1'b0;
        case (i_opsel)
            OP_AND:  o_s = i_a & i_b;
            OP_OR:   o_s = i_a | i_b;
            OP_XOR:  o_s = i_a ^ i_b;
            OP_NOT:  o_s = ~i_a;
            OP_ADD:  {o_co, o_s} = w_add;
            OP_SUB:  {o_co, o_s} = w_sub;
            OP_SHL:  {o_co, o_s} = {i_a, i_ci};
            default: o_s = '0;
        endcase
    end
endmodule

// File: rtl/carry_chain_seq.sv
// carry_chain_seq: runs one N-word ALU operation through a single W-bit slice, LS word first,
// feeding each slice carry-out back as the next word's carry-in.
module carry_chain_seq
    import alu_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    carry_chain_seq_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    seq_state_e     r_state;
    seq_state_e     w_next;
    opsel_e         r_op;
    logic [IW-1:0]  r_idx;
    logic [W*N-1:0] r_a;
    logic [W*N-1:0] r_b;
    logic [W*N-1:0] r_acc;
    logic [W*N-1:0] r_result;
    logic           r_carry;
    logic           r_cout;
    logic           r_zero;
    logic           r_err;
    logic           w_accept;
    logic           w_rsv;
    logic           w_last;
    logic [W-1:0]   w_s;
    logic           w_co;
    logic [W*N-1:0] w_acc_next;

    assign w_accept = bus.in_valid && (r_state == IDLE);
    assign w_rsv    = (bus.opsel == OP_RESERVED);
    assign w_last   = (r_idx == IW'(N - 1));

    alu_word_slice #(.W(W)) u_slice (
        .i_opsel (r_op),
        .i_a     (r_a[r_idx*W +: W]),
        .i_b     (r_b[r_idx*W +: W]),
        .i_ci    (r_carry),
        .o_s     (w_s),
        .o_co    (w_co)
    );

    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[r_idx*W +: W] = w_s;
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && w_accept)      ? (w_rsv ? DONE : RUN) :
                 (r_state == RUN  && w_last)        ? DONE :
                 (r_state == DONE && bus.out_ready) ? IDLE : r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Working accumulator is separate so the visible result only changes on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_AND;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_op    <= opsel_e'(bus.opsel);
            r_a     <= bus.op_a;
            r_b     <= bus.op_b;
            r_idx   <= '0;
            r_carry <= (bus.opsel == OP_ADD || bus.opsel == OP_SHL) ? bus.cin :
                       (bus.opsel == OP_SUB) ? SUB_INIT_CARRY : 1'b0;
            r_err   <= w_rsv;
            if (w_rsv) begin
                r_result <= '0;
                r_cout   <= 1'b0;
                r_zero   <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_acc   <= w_acc_next;
            r_carry <= w_co;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_result <= w_acc_next;
                r_cout   <= w_co;
                r_zero   <= (w_acc_next == '0);
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.cout      = r_cout;
    assign bus.zero      = r_zero;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_carry_chain_seq.sv
// tb_carry_chain_seq: directed-vector bench for carry_chain_seq with W=8, N=4.
module tb_carry_chain_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    carry_chain_seq_if #(.W(8), .N(4)) bus ();

    carry_chain_seq #(.W(8), .N(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Issue one request; returns edges from the accept edge (inclusive) until out_valid, or -1 on timeout.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, output int lat);
        @(negedge clk);
        bus.opsel = op; bus.op_a = a; bus.op_b = b; bus.cin = ci; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0; bus.op_a = ~a; bus.op_b = ~b; bus.cin = ~ci;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic release_op();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if ({bus.result, bus.cout, bus.zero, bus.err} !== 35'h0) begin n_bad++; $display("FAIL reset_outputs got %h/%b%b%b want 0", bus.result, bus.cout, bus.zero, bus.err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat;
        run_op(3'b100, 32'h0000_00FF, 32'h0000_0001, 1'b0, lat);
        n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL add_latency got %0d want 5", lat); end
        n_cmp++; if (bus.result !== 32'h0000_0100) begin n_bad++; $display("FAIL add1_result got %h want 00000100", bus.result); end
        n_cmp++; if ({bus.cout, bus.zero, bus.err} !== 3'b000) begin n_bad++; $display("FAIL add1_flags got %b want 000", {bus.cout, bus.zero, bus.err}); end
        release_op();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL add1_release got v=%b r=%b want v=0 r=1", bus.out_valid, bus.in_ready); end
        n_cmp++; if (bus.result !== 32'h0000_0100) begin n_bad++; $display("FAIL add1_hold_idle got %h want 00000100", bus.result); end
        run_op(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        n_cmp++; if (bus.result !== 32'h0 || lat !== 5) begin n_bad++; $display("FAIL add2_result got %h lat %0d want 00000000 lat 5", bus.result, lat); end
        n_cmp++; if ({bus.cout, bus.zero, bus.err} !== 3'b110) begin n_bad++; $display("FAIL add2_flags got %b want 110", {bus.cout, bus.zero, bus.err}); end
        release_op();
        run_op(3'b100, 32'h0000_00FF, 32'h0000_0000, 1'b1, lat);
        n_cmp++; if (bus.result !== 32'h0000_0100 || bus.cout !== 1'b0) begin n_bad++; $display("FAIL add_cin got %h/%b want 00000100/0", bus.result, bus.cout); end
        release_op();
    endtask

    task automatic test_sub();
        int lat;
        run_op(3'b110, 32'h0000_0005, 32'h0000_0007, 1'b0, lat);
        n_cmp++; if (bus.result !== 32'hFFFF_FFFE || lat !== 5) begin n_bad++; $display("FAIL sub57_result got %h lat %0d want fffffffe lat 5", bus.result, lat); end
        n_cmp++; if ({bus.cout, bus.zero} !== 2'b00) begin n_bad++; $display("FAIL sub57_flags got %b want 00", {bus.cout, bus.zero}); end
        release_op();
        run_op(3'b110, 32'h0000_0007, 32'h0000_0005, 1'b0, lat);
        n_cmp++; if (bus.result !== 32'h0000_0002) begin n_bad++; $display("FAIL sub75_result got %h want 00000002", bus.result); end
        n_cmp++; if ({bus.cout, bus.zero} !== 2'b10) begin n_bad++; $display("FAIL sub75_flags got %b want 10", {bus.cout, bus.zero}); end
        release_op();
    endtask

    task automatic test_shl();
        int lat;
        run_op(3'b101, 32'h8000_0001, 32'hDEAD_BEEF, 1'b0, lat);
        n_cmp++; if (bus.result !== 32'h0000_0002 || bus.cout !== 1'b1) begin n_bad++; $display("FAIL shl1 got %h/%b want 00000002/1", bus.result, bus.cout); end
        release_op();
        run_op(3'b101, 32'h0000_8000, 32'h0, 1'b1, lat);
        n_cmp++; if (bus.result !== 32'h0001_0001 || bus.cout !== 1'b0) begin n_bad++; $display("FAIL shl2 got %h/%b want 00010001/0", bus.result, bus.cout); end
        release_op();
    endtask

    task automatic test_logic();
        int lat;
        run_op(3'b010, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b1, lat);
        n_cmp++; if (bus.result !== 32'h5A5A_5A5A || bus.cout !== 1'b0) begin n_bad++; $display("FAIL xor got %h/%b want 5a5a5a5a/0", bus.result, bus.cout); end
        release_op();
        run_op(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, lat);
        n_cmp++; if (bus.result !== 32'h00F0_1200) begin n_bad++; $display("FAIL and got %h want 00f01200", bus.result); end
        release_op();
        run_op(3'b001, 32'hF000_0001, 32'h0000_8010, 1'b0, lat);
        n_cmp++; if (bus.result !== 32'hF000_8011) begin n_bad++; $display("FAIL or got %h want f0008011", bus.result); end
        release_op();
        run_op(3'b011, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, lat);
        n_cmp++; if ({bus.result, bus.cout, bus.zero} !== {32'h0, 2'b01}) begin n_bad++; $display("FAIL not got %h/%b%b want 00000000/01", bus.result, bus.cout, bus.zero); end
        release_op();
    endtask

    task automatic test_reserved();
        int lat;
        run_op(3'b111, 32'h1234_5678, 32'h1111_1111, 1'b1, lat);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rsv_latency got %0d want 1", lat); end
        n_cmp++; if ({bus.result, bus.cout, bus.zero, bus.err} !== {32'h0, 3'b011}) begin n_bad++; $display("FAIL rsv_outputs got %h/%b%b%b want 00000000/011", bus.result, bus.cout, bus.zero, bus.err); end
        release_op();
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL rsv_err_hold got %b want 1", bus.err); end
        run_op(3'b100, 32'h0000_0001, 32'h0000_0002, 1'b0, lat);
        n_cmp++; if (bus.err !== 1'b0 || bus.result !== 32'h3) begin n_bad++; $display("FAIL rsv_err_clear got err=%b res=%h want 0/00000003", bus.err, bus.result); end
        release_op();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        run_op(3'b100, 32'h1234_5678, 32'h1111_1111, 1'b0, lat);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.opsel = 3'b000; bus.op_a = 32'h0; bus.op_b = 32'h0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'h2345_6789 || bus.cout !== 1'b0) begin
                n_bad++;
                $display("FAIL backpressure_cycle%0d got v=%b r=%b res=%h c=%b want 1/0/23456789/0", i, bus.out_valid, bus.in_ready, bus.result, bus.cout);
            end
        end
        bus.in_valid = 1'b0;
        release_op();
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.result !== 32'h2345_6789) begin n_bad++; $display("FAIL backpressure_release got r=%b res=%h want 1/23456789", bus.in_ready, bus.result); end
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL out_ready_idle got v=%b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        @(negedge clk);
        bus.opsel = 3'b100; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'h1; bus.cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL midrun_reset got v=%b r=%b want 0/1", bus.out_valid, bus.in_ready); end
        n_cmp++; if ({bus.result, bus.cout, bus.zero, bus.err} !== 35'h0) begin n_bad++; $display("FAIL midrun_reset_outputs got %h want 0", {bus.result, bus.cout, bus.zero, bus.err}); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL midrun_no_valid got %b want 0", bus.out_valid); end
        rst_n = 1'b1;
        run_op(3'b100, 32'h0000_FFFF, 32'h0000_0001, 1'b1, lat);
        n_cmp++; if (bus.result !== 32'h0001_0001 || bus.cout !== 1'b0 || lat !== 5) begin n_bad++; $display("FAIL post_reset_add got %h/%b lat %0d want 00010001/0 lat 5", bus.result, bus.cout, lat); end
        release_op();
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.opsel = 3'b000;
        bus.op_a = 32'h0; bus.op_b = 32'h0; bus.cin = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_shl();
        test_logic();
        test_reserved();
        test_backpressure();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
